ring_switch_rr: RTL and testbench

Parametrised successor to the single-register ring switch in the mini-AIE CGRA fabric.
- Sits between one PE and the unidirectional inter-tile ring.
- Routes ring traffic addressed to this tile to the PE and forwards everything else.
- Injects PE traffic onto the ring.
- Adds per-input FIFO buffering, valid/ready handshakes and round-robin arbitration for the ring output. This replaces change-detection and fixed PE priority.

---
 rtl/ring_switch_rr_if.sv | 13 +
 rtl/ring_switch_rr.sv | 235 +++++++++++++++++++++++
 tb/tb_ring_switch_rr.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ring_switch_rr_if.sv
// Valid/ready packet stream between the ring switch and its neighbours.
// Latency: none (wires only).
// Backpressure: the sink holds ready low to stall; the source keeps valid/data stable.
interface ring_switch_rr_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/ring_switch_rr.sv
// Ring switch: buffers ring and PE traffic, ejects local packets, round-robins ring_out; stats under RING_SWITCH_STATS_EN.
// Latency: 2 cycles from input handshake to output valid; 1 packet/cycle per output when ready stays high.
// Backpressure: in_ready depends only on FIFO occupancy; output stages hold valid/data until accepted.
`default_nettype none

module ring_switch_rr_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              push_vld,
    input  wire logic [DATA_W-1:0] push_dat,
    output logic                   push_rdy,
    input  wire logic              pop,
    output logic                   head_vld,
    output logic [DATA_W-1:0]      head_dat
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;

    assign push_rdy = (count != CNT_W'(DEPTH));
    assign head_vld = (count != '0);
    assign head_dat = mem[rd_ptr];
    assign push     = push_vld && push_rdy;

    // Pointers are exactly log2(DEPTH) wide so they wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module ring_switch_rr #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2,
    parameter int ADDR_LSB = 4,
    parameter int RANK     = 0,
    parameter int DEPTH    = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    ring_switch_rr_if.slave  ring_in,
    ring_switch_rr_if.slave  pe_in,
    ring_switch_rr_if.master ring_out,
    ring_switch_rr_if.master pe_out
`ifdef RING_SWITCH_STATS_EN
    ,
    output logic [15:0]     stat_fwd,
    output logic [15:0]     stat_local
`endif
);
    typedef enum logic {
        SRC_PE   = 1'b0,
        SRC_RING = 1'b1
    } src_e;

    logic              ring_head_vld;
    logic [DATA_W-1:0] ring_head_dat;
    logic              ring_pop;
    logic              ring_in_rdy;
    logic              pe_head_vld;
    logic [DATA_W-1:0] pe_head_dat;
    logic              pe_pop;
    logic              pe_in_rdy;

    logic              ring_local;
    logic              ring_fwd;
    logic              pe_can_load;
    logic              ro_can_load;
    logic              pe_out_load;
    logic              ro_load;
    src_e              ro_grant;
    src_e              rr_ptr;
    src_e              rr_ptr_nxt;

    logic              pe_out_vld_q;
    logic [DATA_W-1:0] pe_out_dat_q;
    logic              ro_vld_q;
    logic [DATA_W-1:0] ro_dat_q;

    ring_switch_rr_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ring_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (ring_in.valid),
        .push_dat (ring_in.data),
        .push_rdy (ring_in_rdy),
        .pop      (ring_pop),
        .head_vld (ring_head_vld),
        .head_dat (ring_head_dat)
    );

    ring_switch_rr_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_pe_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (pe_in.valid),
        .push_dat (pe_in.data),
        .push_rdy (pe_in_rdy),
        .pop      (pe_pop),
        .head_vld (pe_head_vld),
        .head_dat (pe_head_dat)
    );

    assign ring_in.ready = ring_in_rdy;
    assign pe_in.ready   = pe_in_rdy;

    // The single ring head is either local or forward-bound, never both.
    assign ring_local  = ring_head_vld && (ring_head_dat[ADDR_LSB +: ADDR_W] == ADDR_W'(RANK));
    assign ring_fwd    = ring_head_vld && !ring_local;
    assign pe_can_load = !pe_out_vld_q || pe_out.ready;
    assign ro_can_load = !ro_vld_q || ring_out.ready;

    always_comb begin
        pe_out_load = 1'b0;
        ro_load     = 1'b0;
        ro_grant    = SRC_PE;
        ring_pop    = 1'b0;
        pe_pop      = 1'b0;
        rr_ptr_nxt  = rr_ptr;

        if (ring_local && pe_can_load) begin
            pe_out_load = 1'b1;
            ring_pop    = 1'b1;
        end

        // On a tie the source not granted last time wins.
        if (ro_can_load) begin
            if (ring_fwd && pe_head_vld) begin
                ro_load  = 1'b1;
                ro_grant = (rr_ptr == SRC_RING) ? SRC_PE : SRC_RING;
            end else if (ring_fwd) begin
                ro_load  = 1'b1;
                ro_grant = SRC_RING;
            end else if (pe_head_vld) begin
                ro_load  = 1'b1;
                ro_grant = SRC_PE;
            end
        end

        if (ro_load) begin
            rr_ptr_nxt = ro_grant;
            if (ro_grant == SRC_RING) begin
                ring_pop = 1'b1;
            end else begin
                pe_pop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= SRC_RING;
        end else begin
            rr_ptr <= rr_ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_out_vld_q <= 1'b0;
            pe_out_dat_q <= '0;
            ro_vld_q     <= 1'b0;
            ro_dat_q     <= '0;
        end else begin
            if (pe_out_load) begin
                pe_out_vld_q <= 1'b1;
                pe_out_dat_q <= ring_head_dat;
            end else if (pe_out.ready) begin
                pe_out_vld_q <= 1'b0;
            end

            if (ro_load) begin
                ro_vld_q <= 1'b1;
                ro_dat_q <= (ro_grant == SRC_RING) ? ring_head_dat : pe_head_dat;
            end else if (ring_out.ready) begin
                ro_vld_q <= 1'b0;
            end
        end
    end

    assign pe_out.valid   = pe_out_vld_q;
    assign pe_out.data    = pe_out_dat_q;
    assign ring_out.valid = ro_vld_q;
    assign ring_out.data  = ro_dat_q;

`ifdef RING_SWITCH_STATS_EN
    // Remember which source filled ring_out so forwarded traffic can be counted on acceptance.
    src_e ro_src_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ro_src_q   <= SRC_PE;
            stat_fwd   <= '0;
            stat_local <= '0;
        end else begin
            if (ro_load) begin
                ro_src_q <= ro_grant;
            end
            if (ro_vld_q && ring_out.ready && (ro_src_q == SRC_RING)) begin
                stat_fwd <= stat_fwd + 16'd1;
            end
            if (pe_out_vld_q && pe_out.ready) begin
                stat_local <= stat_local + 16'd1;
            end
        end
    end
`endif
endmodule

`default_nettype wire

// File: tb/tb_ring_switch_rr.sv
// Directed scenarios plus randomized traffic scored against per-destination order queues.
module tb_ring_switch_rr;
    localparam int DW   = 8;
    localparam int RANK = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ring_switch_rr_if #(.DATA_W(DW)) ring_in_if ();
    ring_switch_rr_if #(.DATA_W(DW)) pe_in_if ();
    ring_switch_rr_if #(.DATA_W(DW)) ring_out_if ();
    ring_switch_rr_if #(.DATA_W(DW)) pe_out_if ();

`ifdef RING_SWITCH_STATS_EN
    logic [15:0] stat_fwd;
    logic [15:0] stat_local;
`endif

    ring_switch_rr #(
        .DATA_W(DW), .ADDR_W(2), .ADDR_LSB(4), .RANK(RANK), .DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ring_in  (ring_in_if),
        .pe_in    (pe_in_if),
        .ring_out (ring_out_if),
        .pe_out   (pe_out_if)
`ifdef RING_SWITCH_STATS_EN
        ,
        .stat_fwd   (stat_fwd),
        .stat_local (stat_local)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference: ring packets carry bit7=0, PE packets bit7=1, so ring_out tells its source.
    logic [7:0] q_local[$];
    logic [7:0] q_fwd[$];
    logic [7:0] q_pe[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_d;
        logic       prev_ro_vld, prev_ro_rdy, prev_pe_vld, prev_pe_rdy;
        logic [7:0] prev_ro_dat, prev_pe_dat;

        ring_in_if.valid  = 1'b0;
        ring_in_if.data   = '0;
        pe_in_if.valid    = 1'b0;
        pe_in_if.data     = '0;
        ring_out_if.ready = 1'b1;
        pe_out_if.ready   = 1'b1;
        rst_n             = 1'b0;

        #1;
        check("rst_ro_vld", ring_out_if.valid, 0);
        check("rst_ro_dat", ring_out_if.data, 0);
        check("rst_pe_vld", pe_out_if.valid, 0);
        check("rst_pe_dat", pe_out_if.data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_ring_rdy", ring_in_if.ready, 1);
        check("rel_pe_rdy", pe_in_if.ready, 1);
        @(negedge clk);

        // Local packet ejects to the PE.
        ring_in_if.valid = 1'b1;
        ring_in_if.data  = 8'h1A;
        @(negedge clk);
        ring_in_if.valid = 1'b0;
        check("s2_pe_vld_early", pe_out_if.valid, 0);
        @(negedge clk);
        check("s2_pe_vld", pe_out_if.valid, 1);
        check("s2_pe_dat", pe_out_if.data, 8'h1A);
        check("s2_ro_vld", ring_out_if.valid, 0);
        @(negedge clk);
        check("s2_pe_vld_drop", pe_out_if.valid, 0);
        check("s2_ro_vld_late", ring_out_if.valid, 0);

        // Non-local packet forwards.
        ring_in_if.valid = 1'b1;
        ring_in_if.data  = 8'h2B;
        @(negedge clk);
        ring_in_if.valid = 1'b0;
        check("s3_ro_vld_early", ring_out_if.valid, 0);
        @(negedge clk);
        check("s3_ro_vld", ring_out_if.valid, 1);
        check("s3_ro_dat", ring_out_if.data, 8'h2B);
        check("s3_pe_vld", pe_out_if.valid, 0);
        @(negedge clk);
        check("s3_ro_vld_drop", ring_out_if.valid, 0);

        // Simultaneous sources alternate.
        pe_in_if.valid   = 1'b1;
        pe_in_if.data    = 8'h33;
        ring_in_if.valid = 1'b1;
        ring_in_if.data  = 8'h25;
        @(negedge clk);
        pe_in_if.data    = 8'h34;
        ring_in_if.data  = 8'h26;
        @(negedge clk);
        pe_in_if.valid   = 1'b0;
        ring_in_if.valid = 1'b0;
        check("s4_ro0_vld", ring_out_if.valid, 1);
        check("s4_ro0_dat", ring_out_if.data, 8'h33);
        @(negedge clk);
        check("s4_ro1_dat", ring_out_if.data, 8'h25);
        @(negedge clk);
        check("s4_ro2_dat", ring_out_if.data, 8'h34);
        check("s4_pe_vld", pe_out_if.valid, 0);
        @(negedge clk);
        check("s4_ro3_vld", ring_out_if.valid, 1);
        check("s4_ro3_dat", ring_out_if.data, 8'h26);
        @(negedge clk);
        check("s4_ro_vld_drop", ring_out_if.valid, 0);

`ifdef RING_SWITCH_STATS_EN
        check("stat_local", stat_local, 1);
        check("stat_fwd", stat_fwd, 3);
`endif

        // Backpressure: 4 FIFO entries plus the output stage.
        pe_out_if.ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ring_in_if.valid = 1'b1;
            ring_in_if.data  = 8'(8'h10 + i);
            check("s5_ring_rdy", ring_in_if.ready, (i < 5) ? 1 : 0);
            if (i < 5) @(negedge clk);
        end
        check("s5_hold_vld", pe_out_if.valid, 1);
        check("s5_hold_dat", pe_out_if.data, 8'h10);
        pe_out_if.ready = 1'b1;
        @(negedge clk);
        check("s5_ring_rdy_back", ring_in_if.ready, 1);
        check("s5_pe_dat1", pe_out_if.data, 8'h11);
        for (int j = 2; j < 6; j++) begin
            @(negedge clk);
            ring_in_if.valid = 1'b0;
            check("s5_pe_vld", pe_out_if.valid, 1);
            check("s5_pe_dat", pe_out_if.data, 8'(8'h10 + j));
        end
        @(negedge clk);
        check("s5_pe_vld_drop", pe_out_if.valid, 0);

        // Reset in the middle of a clock phase with both outputs occupied.
        pe_out_if.ready   = 1'b0;
        ring_out_if.ready = 1'b0;
        ring_in_if.valid  = 1'b1;
        ring_in_if.data   = 8'h1C;
        pe_in_if.valid    = 1'b1;
        pe_in_if.data     = 8'h3D;
        @(negedge clk);
        ring_in_if.valid = 1'b0;
        pe_in_if.valid   = 1'b0;
        @(negedge clk);
        check("mid_pre_ro_vld", ring_out_if.valid, 1);
        check("mid_pre_pe_vld", pe_out_if.valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_ro_vld", ring_out_if.valid, 0);
        check("mid_ro_dat", ring_out_if.data, 0);
        check("mid_pe_vld", pe_out_if.valid, 0);
        check("mid_pe_dat", pe_out_if.data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_ring_rdy", ring_in_if.ready, 1);
        check("mid_pe_rdy", pe_in_if.ready, 1);
        pe_out_if.ready   = 1'b1;
        ring_out_if.ready = 1'b1;

        // Randomized traffic, then a quiet drain.
        prev_ro_vld = 1'b0; prev_ro_rdy = 1'b1; prev_ro_dat = '0;
        prev_pe_vld = 1'b0; prev_pe_rdy = 1'b1; prev_pe_dat = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (prev_ro_vld && !prev_ro_rdy) begin
                check("rnd_ro_hold_vld", ring_out_if.valid, 1);
                check("rnd_ro_hold_dat", ring_out_if.data, prev_ro_dat);
            end
            if (prev_pe_vld && !prev_pe_rdy) begin
                check("rnd_pe_hold_vld", pe_out_if.valid, 1);
                check("rnd_pe_hold_dat", pe_out_if.data, prev_pe_dat);
            end

            if (cyc < 2500) begin
                ring_in_if.valid  = ($urandom_range(0, 99) < 60);
                ring_in_if.data   = {2'b00, 2'($urandom_range(0, 3)), 4'($urandom)};
                pe_in_if.valid    = ($urandom_range(0, 99) < 50);
                pe_in_if.data     = {1'b1, 1'($urandom), 2'($urandom_range(0, 3)), 4'($urandom)};
                ring_out_if.ready = ($urandom_range(0, 99) < 70);
                pe_out_if.ready   = ($urandom_range(0, 99) < 70);
            end else begin
                ring_in_if.valid  = 1'b0;
                pe_in_if.valid    = 1'b0;
                ring_out_if.ready = 1'b1;
                pe_out_if.ready   = 1'b1;
            end

            if (ring_in_if.valid && ring_in_if.ready) begin
                if (ring_in_if.data[5:4] == 2'(RANK)) q_local.push_back(ring_in_if.data);
                else q_fwd.push_back(ring_in_if.data);
            end
            if (pe_in_if.valid && pe_in_if.ready) q_pe.push_back(pe_in_if.data);

            if (pe_out_if.valid && pe_out_if.ready) begin
                if (q_local.size() == 0) check("rnd_pe_unexpected", pe_out_if.data, 32'hFFFF_FFFF);
                else begin
                    exp_d = q_local.pop_front();
                    check("rnd_pe_dat", pe_out_if.data, exp_d);
                end
            end
            if (ring_out_if.valid && ring_out_if.ready) begin
                if (ring_out_if.data[7]) begin
                    if (q_pe.size() == 0) check("rnd_ro_pe_unexpected", ring_out_if.data, 32'hFFFF_FFFF);
                    else begin
                        exp_d = q_pe.pop_front();
                        check("rnd_ro_pe_dat", ring_out_if.data, exp_d);
                    end
                end else begin
                    if (q_fwd.size() == 0) check("rnd_ro_fwd_unexpected", ring_out_if.data, 32'hFFFF_FFFF);
                    else begin
                        exp_d = q_fwd.pop_front();
                        check("rnd_ro_fwd_dat", ring_out_if.data, exp_d);
                    end
                end
            end

            prev_ro_vld = ring_out_if.valid; prev_ro_rdy = ring_out_if.ready; prev_ro_dat = ring_out_if.data;
            prev_pe_vld = pe_out_if.valid;   prev_pe_rdy = pe_out_if.ready;   prev_pe_dat = pe_out_if.data;
        end
        check("drain_local_left", q_local.size(), 0);
        check("drain_fwd_left", q_fwd.size(), 0);
        check("drain_pe_left", q_pe.size(), 0);
        check("drain_ro_vld", ring_out_if.valid, 0);
        check("drain_pe_vld", pe_out_if.valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
